// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg -- shared display constants for the six-digit scanned display.
//   DIGIT_CNT  : number of multiplexed digits
//   AN_OFF     : anode pattern with every digit disabled (active-low)
//   SEG_BLANK  : segment pattern with every segment dark, dp included
//   GLYPH_TBL  : active-low g..a patterns for decimal digits 0..9
//   glyph()    : table lookup; out-of-range digits map to all-dark
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    localparam int         DIGIT_CNT = 6;
    localparam logic [5:0] AN_OFF    = 6'h3F;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef logic [2:0] digit_idx_t;

    // Entry n is the glyph for decimal n (entry 9 is the leftmost element).
    localparam logic [9:0][6:0] GLYPH_TBL = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    function automatic logic [6:0] glyph(input logic [3:0] digit);
        logic [6:0] g;
        if (digit <= 4'd9) begin
            g = GLYPH_TBL[digit];
        end else begin
            g = 7'h7F;
        end
        return g;
    endfunction

endpackage

// File: rtl/seg_scan_bin2bcd6.sv
// -----------------------------------------------------------------------------
// bin2bcd6 -- combinational 6-bit binary to two-digit decimal converter.
//   i_bin  : binary value 0..63
//   o_tens : tens digit 0..6
//   o_ones : ones digit 0..9
// -----------------------------------------------------------------------------
module bin2bcd6 (
    input  logic [5:0] i_bin,
    output logic [3:0] o_tens,
    output logic [3:0] o_ones
);

    logic [5:0] w_rem;

    // Subtract the largest multiple of ten; the remainder is the ones digit.
    always_comb begin
        o_tens = 4'd0;
        w_rem  = i_bin;
        if (i_bin >= 6'd60) begin
            o_tens = 4'd6;
            w_rem  = i_bin - 6'd60;
        end else if (i_bin >= 6'd50) begin
            o_tens = 4'd5;
            w_rem  = i_bin - 6'd50;
        end else if (i_bin >= 6'd40) begin
            o_tens = 4'd4;
            w_rem  = i_bin - 6'd40;
        end else if (i_bin >= 6'd30) begin
            o_tens = 4'd3;
            w_rem  = i_bin - 6'd30;
        end else if (i_bin >= 6'd20) begin
            o_tens = 4'd2;
            w_rem  = i_bin - 6'd20;
        end else if (i_bin >= 6'd10) begin
            o_tens = 4'd1;
            w_rem  = i_bin - 6'd10;
        end else begin
            o_tens = 4'd0;
            w_rem  = i_bin;
        end
    end

    assign o_ones = w_rem[3:0];

endmodule

// File: rtl/seg_scan.sv
// -----------------------------------------------------------------------------
// seg_scan -- six-digit multiplexed 7-segment driver with pause blinking.
//   clk      : system clock, all logic on posedge
//   rst      : synchronous active-high reset
//   en       : display enable (0 = all digits dark, counters keep running)
//   u_tot    : total time 0..63        -> digits 0 (tens) / 1 (ones)
//   u_cur    : current-stage time 0..63 -> digits 2 / 3
//   u_wat    : water level 0..63        -> digits 4 / 5
//   fl_disp  : blink request; digits 0..3 flash, digits 4/5 stay lit
//   an       : active-low digit enables (registered)
//   seg      : active-low segments, seg[7]=dp always off (registered)
// Build option: define SEG_LZB_EN to blank tens digits that are zero.
// -----------------------------------------------------------------------------
module seg_scan
    import seg_scan_pkg::*;
#(
    parameter int SCAN_CMAX  = 50000,
    parameter int BLINK_CMAX = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] u_tot,
    input  logic [5:0] u_cur,
    input  logic [5:0] u_wat,
    input  logic       fl_disp,
    output logic [5:0] an,
    output logic [7:0] seg
);

    localparam int SCAN_W  = (SCAN_CMAX  > 1) ? $clog2(SCAN_CMAX)  : 1;
    localparam int BLINK_W = (BLINK_CMAX > 1) ? $clog2(BLINK_CMAX) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CMAX - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CMAX - 1);
    localparam digit_idx_t         IDX_LAST   = digit_idx_t'(DIGIT_CNT - 1);

    logic [SCAN_W-1:0]  r_scan_cnt;
    logic [BLINK_W-1:0] r_blink_cnt;
    digit_idx_t         r_idx;
    logic               r_phase_on;
    logic [5:0]         r_f_tot;
    logic [5:0]         r_f_cur;
    logic [5:0]         r_f_wat;
    logic [5:0]         r_an;
    logic [7:0]         r_seg;

    logic               w_scan_tc;
    logic               w_wrap;
    logic [5:0]         w_val;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;
    logic [3:0]         w_digit;
    logic               w_lz_blank;
    logic               w_blink_blank;
    logic               w_blank;

    assign w_scan_tc = (r_scan_cnt == SCAN_LAST);
    assign w_wrap    = w_scan_tc && (r_idx == IDX_LAST);

    // Scan counter and digit index; frame values are captured only as the
    // index wraps to 0 so one frame never mixes old and new inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_idx      <= 3'd0;
            r_f_tot    <= 6'd0;
            r_f_cur    <= 6'd0;
            r_f_wat    <= 6'd0;
        end else if (w_scan_tc) begin
            r_scan_cnt <= '0;
            if (w_wrap) begin
                r_idx   <= 3'd0;
                r_f_tot <= u_tot;
                r_f_cur <= u_cur;
                r_f_wat <= u_wat;
            end else begin
                r_idx <= r_idx + 3'd1;
            end
        end else begin
            r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
        end
    end

    // Blink timer; parked at count 0 / phase on whenever blinking is not
    // requested, so a new blink request always starts with digits visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (!fl_disp) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
        end
    end

    // Select the frame value belonging to the current digit pair.
    always_comb begin
        w_val = 6'd0;
        case (r_idx[2:1])
            2'd0:    w_val = r_f_tot;
            2'd1:    w_val = r_f_cur;
            2'd2:    w_val = r_f_wat;
            default: w_val = 6'd0;
        endcase
    end

    bin2bcd6 u_bin2bcd6 (
        .i_bin  (w_val),
        .o_tens (w_tens),
        .o_ones (w_ones)
    );

    // Even index = tens digit, odd index = ones digit.
    assign w_digit = r_idx[0] ? w_ones : w_tens;

`ifdef SEG_LZB_EN
    assign w_lz_blank = ~r_idx[0] & (w_tens == 4'd0);
`else
    assign w_lz_blank = 1'b0;
`endif

    // Only the two time fields (digits 0..3) flash; the water level stays lit.
    assign w_blink_blank = ~r_phase_on & (r_idx < 3'd4);
    assign w_blank       = ~en | w_blink_blank | w_lz_blank;

    // Output registers: one cycle behind the index they display.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else if (w_blank) begin
            r_an  <= AN_OFF;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(6'd1 << r_idx);
            r_seg <= {1'b1, glyph(w_digit)};
        end
    end

    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_scan -- self-checking bench for seg_scan (SCAN_CMAX=4, BLINK_CMAX=16).
// A cycle-count based reference model predicts an/seg every cycle; a set of
// hand-computed literal expectations pins the model, followed by a randomized
// run. Honours SEG_LZB_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_seg_scan;

    localparam int SC = 4;
    localparam int BC = 16;
`ifdef SEG_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [5:0] u_tot;
    logic [5:0] u_cur;
    logic [5:0] u_wat;
    logic       fl_disp;
    logic [5:0] an;
    logic [7:0] seg;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [6:0] gl_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    seg_scan #(.SCAN_CMAX(SC), .BLINK_CMAX(BC)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .u_tot   (u_tot),
        .u_cur   (u_cur),
        .u_wat   (u_wat),
        .fl_disp (fl_disp),
        .an      (an),
        .seg     (seg)
    );

    always #5 clk = ~clk;

    // Reference model: position in the scan is just the number of cycles
    // since reset; blink phase follows from how long fl_disp has been high.
    int         t_m  = 0;
    int         bk_m = 0;
    int         m_idx, m_val, m_dig;
    bit         m_on, m_blank;
    logic [5:0] f_tot = 6'd0, f_cur = 6'd0, f_wat = 6'd0;
    logic [5:0] exp_an  = 6'h3F;
    logic [7:0] exp_seg = 8'hFF;

    always @(posedge clk) begin
        if (rst) begin
            t_m = 0; bk_m = 0;
            f_tot = 6'd0; f_cur = 6'd0; f_wat = 6'd0;
            exp_an = 6'h3F; exp_seg = 8'hFF;
        end else begin
            m_idx = (t_m / SC) % 6;
            m_on  = ((bk_m / BC) % 2) == 0;
            case (m_idx / 2)
                0:       m_val = int'(f_tot);
                1:       m_val = int'(f_cur);
                default: m_val = int'(f_wat);
            endcase
            m_dig   = (m_idx % 2 == 0) ? m_val / 10 : m_val % 10;
            m_blank = !en || (!m_on && m_idx < 4) || (LZB && m_idx % 2 == 0 && m_dig == 0);
            if (m_blank) begin
                exp_an = 6'h3F; exp_seg = 8'hFF;
            end else begin
                exp_an  = 6'h3F & ~(6'd1 << m_idx);
                exp_seg = {1'b1, gl_tab[m_dig]};
            end
            if ((t_m % (6 * SC)) == 6 * SC - 1) begin
                f_tot = u_tot; f_cur = u_cur; f_wat = u_wat;
            end
            t_m  = t_m + 1;
            bk_m = fl_disp ? bk_m + 1 : 0;
        end
    end

    // Compare DUT against the model on every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (chk_en) begin
            n_chk = n_chk + 1;
            if (an !== exp_an || seg !== exp_seg) begin
                n_err = n_err + 1;
                $display("FAIL model t=%0t: an=%b seg=%b expected an=%b seg=%b",
                         $time, an, seg, exp_an, exp_seg);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string nm, input logic [5:0] a, input logic [7:0] s);
        n_chk = n_chk + 1;
        if (an !== a || seg !== s) begin
            n_err = n_err + 1;
            $display("FAIL %s: an=%b seg=%b expected an=%b seg=%b", nm, an, seg, a, s);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; fl_disp = 1'b0;
        u_tot = 6'd45; u_cur = 6'd7; u_wat = 6'd63;
        step(3);
        lit("reset", 6'h3F, 8'hFF);
        chk_en = 1'b1;
        rst = 1'b0;
        step(1);                                   // after edge 1: frame still 0
        lit("first_frame_zero", LZB ? 6'h3F : 6'h3E, LZB ? 8'hFF : 8'hC0);
        step(24);                                  // edge 25: new frame digit 0
        lit("d0_tens45", 6'h3E, 8'h99);
        step(4);
        lit("d1_ones45", 6'h3D, 8'h92);
        step(4);
        lit("d2_tens07", LZB ? 6'h3F : 6'h3B, LZB ? 8'hFF : 8'hC0);
        u_cur = 6'd12;                             // mid-frame change
        step(4);
        lit("d3_still7", 6'h37, 8'hF8);
        step(4);
        lit("d4_tens63", 6'h2F, 8'h82);
        step(4);
        lit("d5_ones63", 6'h1F, 8'hB0);
        step(12);                                  // edge 57: next frame digit 2
        lit("d2_tens12", 6'h3B, 8'hF9);
        step(4);
        lit("d3_ones12", 6'h37, 8'hA4);
        u_tot = 6'd0;
        step(12);                                  // edge 73: digit 0 of u_tot=0
        lit("utot0_tens", LZB ? 6'h3F : 6'h3E, LZB ? 8'hFF : 8'hC0);
        step(4);
        lit("utot0_ones", 6'h3D, 8'hC0);
        fl_disp = 1'b1;                            // blink for 64 cycles
        step(20);                                  // edge 97: phase off, digit 0
        lit("blink_off_d0", 6'h3F, 8'hFF);
        step(8);                                   // edge 105: digit 2
        lit("blink_off_d2", 6'h3F, 8'hFF);
        step(36);                                  // edge 141
        fl_disp = 1'b0;
        step(4);                                   // edge 145
        en = 1'b0;
        step(1);
        lit("en_off", 6'h3F, 8'hFF);
        en = 1'b1;
        step(11);                                  // edge 157: digit 3 showing
        rst = 1'b1;
        step(1);
        lit("reset_mid", 6'h3F, 8'hFF);
        rst = 1'b0;
        step(1);
        lit("post_reset_d0", LZB ? 6'h3F : 6'h3E, LZB ? 8'hFF : 8'hC0);
        step(4);
        lit("post_reset_d1", 6'h3D, 8'hC0);

        // Randomized run: runs of en/fl_disp, sporadic value changes and resets.
        u_tot = 6'd33; u_cur = 6'd21; u_wat = 6'd58;
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 39) == 0) fl_disp = ~fl_disp;
            if ($urandom_range(0, 29) == 0) u_tot = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) u_cur = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) u_wat = 6'($urandom_range(0, 63));
            step(1);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter SCAN_CMAX, default 50000, clk cycles each digit is driven.
REQ-002 SHALL have parameter BLINK_CMAX, default 25000000, clk cycles per blink half-period.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  display enable, driven by the controller's ioh.
REQ-006 SHALL have port u_tot  input  6  total time, binary 0..63.
REQ-007 SHALL have port u_cur  input  6  current-stage time, binary 0..63.
REQ-008 SHALL have port u_wat  input  6  water level, binary 0..63.
REQ-009 SHALL have port fl_disp  input  1  blink request (paused).
REQ-010 SHALL have port an  output  6  digit enables, active-low; an[i] selects digit i.
REQ-011 SHALL have port seg  output  8  segments, active-low; seg[7]=dp, seg[6:0]=g..a.

Function
REQ-012 SHALL run a scan counter 0..SCAN_CMAX-1; on terminal count, digit index advances 0->1->...->5->0.
REQ-013 SHALL map digits: 0/1 = u_tot tens/ones, 2/3 = u_cur tens/ones, 4/5 = u_wat tens/ones.
REQ-014 SHALL sample u_tot, u_cur, u_wat into frame registers only in the cycle the index wraps 5->0; input changes mid-frame are not shown until the next frame.
REQ-015 SHALL convert each frame value to tens (0..6) and ones (0..9) decimal digits.
REQ-016 SHALL register an and seg; both reflect a new digit index exactly one cycle after the index changes.
REQ-017 SHALL drive exactly one an bit low while en=1 and that digit is not blanked; dp (seg[7]) always 1.
REQ-018 SHALL encode glyphs active-low g..a: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-019 SHALL, with en=0, hold an=111111 and seg=11111111; scan and blink counters keep running.
REQ-020 SHALL run a blink counter 0..BLINK_CMAX-1 toggling phase on terminal count, only while fl_disp=1.
REQ-021 SHALL, while fl_disp=0, hold blink counter at 0 and phase=on, so blinking always starts visible.
REQ-022 SHALL blank digits 0..3 (an bit high, seg=FF) during phase=off; digits 4/5 (u_wat) never blink.
REQ-023 SHALL, on fl_disp falling, restore visible output on the next digit update, regardless of phase.

Reset
REQ-024 SHALL on rst=1: scan counter 0, index 0, blink counter 0, phase on, frame registers 0, an=111111, seg=11111111.
REQ-025 SHALL, on reset mid-frame, restart at digit 0 with frame registers 0 until the first wrap after reset.

Configuration
REQ-026 SHALL, with SEG_LZB_EN defined, blank a tens digit equal to 0 (its an bit high, seg=FF).
REQ-027 SHALL, without SEG_LZB_EN, display tens digit 0 as glyph '0'.

Structure
REQ-028 SHALL place digit count (6), glyph table and blank pattern (8'hFF) in the shared display package.
REQ-029 SHALL use one sub-module, bin2bcd6: 6-bit binary in, 4-bit tens and ones out, combinational.

Verification (bench: SCAN_CMAX=4, BLINK_CMAX=16)
REQ-030 SHALL cover: rst, en=1, u_tot=45, u_cur=7, u_wat=63 -> after first wrap, digits 0..5 show 4,5,0,7,6,3 (0 blanked under SEG_LZB_EN), each for 4 cycles.
REQ-031 SHALL cover: change u_cur 7->12 at digit 2 -> current frame still shows 07; next frame shows 12.
REQ-032 SHALL cover: fl_disp=1 for 64 cycles -> digits 0..3 visible 16 cycles, blanked 16, alternating; digits 4/5 never blank.
REQ-033 SHALL cover: en=0 mid-scan -> next cycle an=111111, seg=FF; en=1 -> resumes at current index.
REQ-034 SHALL cover: rst asserted at digit 3 -> next cycle an=111111, seg=FF, index 0; value 0 shown until first wrap.
REQ-035 SHALL cover: u_tot=0 -> tens digit shows '0' (1000000) without SEG_LZB_EN, blank with it.
